// File: rtl/axi_slv_resp_engine.sv
// AXI4 slave response engine: drains write-response queue onto B and
// read header/data queues onto R with registered, valid/ready-safe outputs.
// Optional error counters: define AXI_SLV_RESP_ERR_CNT_EN.
module axi_slv_resp_engine #(
  parameter int ID_W   = 4,
  parameter int DATA_W = 256,
  parameter int LEN_W  = 8,
  parameter int RESP_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_resp_valid,
  input  logic [ID_W-1:0]   wr_resp_id,
  input  logic [RESP_W-1:0] wr_resp_code,
  output logic              wr_resp_pop,
  input  logic              rd_hdr_valid,
  input  logic [ID_W-1:0]   rd_hdr_id,
  input  logic [RESP_W-1:0] rd_hdr_code,
  input  logic [LEN_W-1:0]  rd_hdr_len,
  output logic              rd_hdr_pop,
  input  logic              rd_data_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_data_pop,
  output logic [ID_W-1:0]   BID,
  output logic [RESP_W-1:0] BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [RESP_W-1:0] RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY
`ifdef AXI_SLV_RESP_ERR_CNT_EN
  ,
  output logic [15:0]       b_err_cnt,
  output logic [15:0]       r_err_cnt
`endif
);

  typedef enum logic {
    R_IDLE,
    R_BURST
  } r_state_t;

  r_state_t            r_state;

  logic                r_bvalid;
  logic [ID_W-1:0]     r_bid;
  logic [RESP_W-1:0]   r_bresp;

  logic [ID_W-1:0]     r_id_q;
  logic [RESP_W-1:0]   r_code_q;
  logic [LEN_W-1:0]    r_len_q;
  logic [LEN_W:0]      r_beat_cnt;

  logic                r_rvalid;
  logic [ID_W-1:0]     r_rid;
  logic [DATA_W-1:0]   r_rdata;
  logic [RESP_W-1:0]   r_rresp;
  logic                r_rlast;

  logic                w_b_free;
  logic                w_wr_pop;
  logic                w_r_free;
  logic                w_err;
  logic                w_last;
  logic                w_r_load;
  logic                w_hdr_take;

  assign w_b_free   = !r_bvalid || BREADY;
  assign w_wr_pop   = w_b_free && wr_resp_valid;

  assign w_r_free   = !r_rvalid || RREADY;
  assign w_err      = r_code_q[1];
  assign w_last     = (r_beat_cnt == {1'b0, r_len_q});
  assign w_r_load   = (r_state == R_BURST) && w_r_free &&
                      (rd_data_valid || w_err);
  assign w_hdr_take = (r_state == R_IDLE) && rd_hdr_valid;

  // Queue pops are held low while reset is asserted.
  assign wr_resp_pop = w_wr_pop && !rst;
  assign rd_hdr_pop  = w_hdr_take && !rst;
  assign rd_data_pop = w_r_load && !w_err && !rst;

  assign BID    = r_bid;
  assign BRESP  = r_bresp;
  assign BVALID = r_bvalid;

  assign RID    = r_rid;
  assign RDATA  = r_rdata;
  assign RRESP  = r_rresp;
  assign RLAST  = r_rlast;
  assign RVALID = r_rvalid;

  // B slot: load on pop, clear on handshake without a refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bvalid <= 1'b0;
      r_bid    <= '0;
      r_bresp  <= '0;
    end else if (w_wr_pop) begin
      r_bvalid <= 1'b1;
      r_bid    <= wr_resp_id;
      r_bresp  <= wr_resp_code;
    end else if (BREADY) begin
      r_bvalid <= 1'b0;
    end
  end

  // R FSM: latch header in idle, then emit len+1 beats into the R slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= R_IDLE;
      r_id_q     <= '0;
      r_code_q   <= '0;
      r_len_q    <= '0;
      r_beat_cnt <= '0;
      r_rvalid   <= 1'b0;
      r_rid      <= '0;
      r_rdata    <= '0;
      r_rresp    <= '0;
      r_rlast    <= 1'b0;
    end else begin
      if (w_r_load) begin
        r_rvalid   <= 1'b1;
        r_rid      <= r_id_q;
        r_rresp    <= r_code_q;
        r_rlast    <= w_last;
        r_rdata    <= w_err ? '0 : rd_data;
        r_beat_cnt <= r_beat_cnt + (LEN_W+1)'(1);
      end else if (RREADY) begin
        r_rvalid   <= 1'b0;
      end
      unique case (r_state)
        R_IDLE: begin
          if (rd_hdr_valid) begin
            r_id_q     <= rd_hdr_id;
            r_code_q   <= rd_hdr_code;
            r_len_q    <= rd_hdr_len;
            r_beat_cnt <= '0;
            r_state    <= R_BURST;
          end
        end
        R_BURST: begin
          if (w_r_load && w_last) begin
            r_state <= R_IDLE;
          end
        end
      endcase
    end
  end

`ifdef AXI_SLV_RESP_ERR_CNT_EN
  logic [15:0] r_b_err_cnt;
  logic [15:0] r_r_err_cnt;

  assign b_err_cnt = r_b_err_cnt;
  assign r_err_cnt = r_r_err_cnt;

  // Saturating counts of error responses handed to the master.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b_err_cnt <= '0;
      r_r_err_cnt <= '0;
    end else begin
      if (r_bvalid && BREADY && r_bresp[1] &&
          (r_b_err_cnt != 16'hFFFF)) begin
        r_b_err_cnt <= r_b_err_cnt + 16'd1;
      end
      if (r_rvalid && RREADY && r_rlast && r_rresp[1] &&
          (r_r_err_cnt != 16'hFFFF)) begin
        r_r_err_cnt <= r_r_err_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
